// File: rtl/mod_arith_pkg.sv
// Shared types and default sizing for the mod-11 issue stage and its helpers.
package mod_arith_pkg;

  localparam int MODULUS_DEF = 11;
  localparam int W_DEF       = 4;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE, OUT} state_t;

  typedef struct packed {
    logic             sub;
    logic [W_DEF-1:0] x;
    logic [W_DEF-1:0] y;
  } op_t;

endpackage

// File: rtl/mod_reduce.sv
// Single conditional subtraction: r = (v >= M) ? v - M : v, plus an in_range flag.
module mod_reduce #(
  parameter int W = 4,
  parameter int M = 11
) (
  input  logic [W-1:0] v,
  output logic [W-1:0] r,
  output logic         in_range
);

  // Compare one bit wider so that M == 2**W still works.
  localparam logic [W:0]   M_WIDE = (W+1)'(M);
  localparam logic [W-1:0] M_TRUNC = W'(M);

  assign in_range = ({1'b0, v} < M_WIDE);
  assign r        = in_range ? v : (v - M_TRUNC);

endmodule

// File: rtl/mod_op_sequencer.sv
// Issue stage for the combinational mod-MODULUS adder/subtractor.
// Build option MOD_REDUCE_EN: reduce out-of-range operands instead of flagging an error.
module mod_op_sequencer
  import mod_arith_pkg::*;
#(
  parameter int MODULUS = MODULUS_DEF,
  parameter int W       = W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_sub,
  input  logic [W-1:0]     cmd_x,
  input  logic [W-1:0]     cmd_y,
  output logic             add_s,
  output logic [W-1:0]     add_x,
  output logic [W-1:0]     add_y,
  input  logic [W-1:0]     add_z,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_z,
  output logic             res_err,
  output logic [CNT_W-1:0] op_cnt
);

  localparam logic [W:0] MOD_WIDE = (W+1)'(MODULUS);

  state_t           state_reg, state_next;
  op_t              op_reg;
  logic             cmd_ready_reg;
  logic             add_s_reg;
  logic [W-1:0]     add_x_reg, add_y_reg;
  logic [W-1:0]     res_z_reg;
  logic             res_err_reg;
  logic [CNT_W-1:0] op_cnt_reg;

  logic [W-1:0]     red_x, red_y;
  logic             x_in_range, y_in_range;
  logic             accept, handoff;

  // For in-range operands the reduced value equals the operand, so the adder
  // is always fed from the reducers regardless of build option.
  mod_reduce #(.W(W), .M(MODULUS)) u_reduce_x (
    .v        (op_reg.x),
    .r        (red_x),
    .in_range (x_in_range)
  );

  mod_reduce #(.W(W), .M(MODULUS)) u_reduce_y (
    .v        (op_reg.y),
    .r        (red_y),
    .in_range (y_in_range)
  );

  assign accept  = (state_reg == IDLE) && cmd_valid && cmd_ready_reg;
  assign handoff = (state_reg == OUT) && res_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept) state_next = CHECK;
`ifdef MOD_REDUCE_EN
      CHECK: state_next = ISSUE;
`else
      CHECK: state_next = (x_in_range && y_in_range) ? ISSUE : OUT;
`endif
      ISSUE: state_next = OUT;
      OUT:   if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      cmd_ready_reg <= 1'b0;
      add_s_reg     <= 1'b0;
      add_x_reg     <= '0;
      add_y_reg     <= '0;
      res_z_reg     <= '0;
      res_err_reg   <= 1'b0;
      op_cnt_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      // Registered so it stays low through the reset edge itself.
      cmd_ready_reg <= (state_next == IDLE);
      if (accept) begin
        op_reg <= '{sub: cmd_sub, x: cmd_x, y: cmd_y};
      end
      if (state_reg == CHECK && state_next == ISSUE) begin
        add_s_reg <= op_reg.sub;
        add_x_reg <= red_x;
        add_y_reg <= red_y;
      end
      if (state_reg == ISSUE) begin
        res_z_reg   <= add_z;
        res_err_reg <= ({1'b0, add_z} >= MOD_WIDE);
      end else if (state_reg == CHECK && state_next == OUT) begin
        res_z_reg   <= '0;
        res_err_reg <= 1'b1;
      end
      if (handoff && !res_err_reg) begin
        op_cnt_reg <= op_cnt_reg + 1'b1;
      end
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign add_s     = add_s_reg;
  assign add_x     = add_x_reg;
  assign add_y     = add_y_reg;
  assign res_valid = (state_reg == OUT);
  assign res_z     = res_z_reg;
  assign res_err   = res_err_reg;
  assign op_cnt    = op_cnt_reg;

endmodule

// File: tb/tb_mod_op_sequencer.sv
// Self-checking bench for mod_op_sequencer driving a behavioural mod-11 adder (MAIN).
// Expectations follow the MOD_REDUCE_EN build option when it is defined.
module tb_mod_op_sequencer;

  localparam int M = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_sub;
  logic [3:0] cmd_x, cmd_y;
  logic       add_s;
  logic [3:0] add_x, add_y, add_z;
  logic       res_valid, res_ready;
  logic [3:0] res_z;
  logic       res_err;
  logic [7:0] op_cnt;
  logic       force_fault;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference state kept by the bench.
  int mdl_cnt = 0;
  int mdl_as  = 0;
  int mdl_ax  = 0;
  int mdl_ay  = 0;

  always #5 clk = ~clk;

  mod_op_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sub   (cmd_sub),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .add_s     (add_s),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_z     (add_z),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_z     (res_z),
    .res_err   (res_err),
    .op_cnt    (op_cnt)
  );

  // MAIN: combinational mod-11 adder/subtractor, with an injectable fault.
  always_comb begin
    if (force_fault)
      add_z = 4'd12;
    else if (add_s)
      add_z = 4'((int'(add_x) - int'(add_y) + M) % M);
    else
      add_z = 4'((int'(add_x) + int'(add_y)) % M);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected outcome of one command, from the arithmetic rules only.
  function automatic void model(input bit sub, input int x, input int y, input bit fault,
                                output int z, output bit err, output int lat,
                                output bit issued, output int a, output int b);
    bit oor;
    a = x;
    b = y;
    oor = (x >= M) || (y >= M);
`ifdef MOD_REDUCE_EN
    if (a >= M) a -= M;
    if (b >= M) b -= M;
    oor = 1'b0;
`endif
    if (oor) begin
      z = 0; err = 1'b1; lat = 1; issued = 1'b0;
    end else begin
      z = sub ? ((a - b) % M + M) % M : (a + b) % M;
      err = 1'b0; lat = 2; issued = 1'b1;
      if (fault) begin
        z = 12; err = 1'b1;
      end
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_add", {add_s, add_x, add_y}, 0);
    check("rst_res", {res_valid, res_err, res_z}, 0);
    check("rst_op_cnt", op_cnt, 0);
    mdl_cnt = 0; mdl_as = 0; mdl_ax = 0; mdl_ay = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_res_valid", res_valid, 0);
  endtask

  task automatic run_cmd(input bit sub, input int x, input int y, input int hold);
    int z, lat, a, b, n;
    bit err, issued;
    model(sub, x, y, force_fault, z, err, lat, issued, a, b);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_sub = sub; cmd_x = 4'(x); cmd_y = 4'(y); cmd_valid = 1'b1;
    res_ready = (hold == 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("latency", n, lat);
    check("res_valid", res_valid, 1);
    check("res_z", res_z, z);
    check("res_err", res_err, err);
    if (issued) begin
      mdl_as = sub; mdl_ax = a; mdl_ay = b;
    end
    check("add_sxy", {add_s, add_x, add_y}, {mdl_as[0], mdl_ax[3:0], mdl_ay[3:0]});
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_x = 4'($urandom_range(0, 15)); cmd_y = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      check("hold_valid", res_valid, 1);
      check("hold_res_z", res_z, z);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_add", {add_s, add_x, add_y}, {mdl_as[0], mdl_ax[3:0], mdl_ay[3:0]});
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    if (!err) mdl_cnt = (mdl_cnt + 1) % 256;
    check("handoff_valid", res_valid, 0);
    check("handoff_cmd_ready", cmd_ready, 1);
    check("op_cnt", op_cnt, mdl_cnt);
    $display("cmd sub=%0d x=%0d y=%0d -> z=%0d err=%0d lat=%0d op_cnt=%0d",
             sub, x, y, res_z, res_err, n, op_cnt);
  endtask

  initial begin
    int n;
    force_fault = 1'b0;
    cmd_sub = 1'b0; cmd_x = '0; cmd_y = '0;
    do_reset();

    // Directed basics.
    run_cmd(0, 7, 6, 0);
    check("first_op_cnt", op_cnt, 1);
    run_cmd(1, 3, 9, 0);
    run_cmd(1, 0, 0, 0);

    // Exhaustive in-range sweep from a clean counter.
    do_reset();
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < M; x++)
        for (int y = 0; y < M; y++)
          run_cmd(s[0], x, y, 0);
    check("sweep_op_cnt", op_cnt, 242);

    // Random good ops up to the counter's top value, then fault, then wrap.
    while (mdl_cnt != 255)
      run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, M-1), $urandom_range(0, M-1), 0);
    force_fault = 1'b1;
    run_cmd(0, 2, 3, 0);
    check("fault_op_cnt", op_cnt, 255);
    force_fault = 1'b0;
    run_cmd(0, 2, 3, 0);
    check("wrap_op_cnt", op_cnt, 0);

    // Out-of-range operands, then random full-width operands with random stalls.
    run_cmd(0, 13, 4, 0);
    for (int i = 0; i < 24; i++)
      run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 2));

    // Long stall in OUT with a competing command.
    run_cmd(0, 5, 8, 10);

    // Reset while the adder is being issued.
    cmd_sub = 1'b0; cmd_x = 4'd4; cmd_y = 4'd4; cmd_valid = 1'b1; res_ready = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("issue_no_valid", res_valid, 0);
    do_reset();
    run_cmd(0, 10, 10, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
